pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline; drives the hold/clear of pc, if_id, id_ex, ex_mem, mem_wb.
//  Merges per-stage stall requests into a prefix stall vector and runs exception-flush sequencing with PC redirect.
//  Sits beside the datapath; every pipeline register samples stall[] and flush from this block.
// PARAMETERS
//  ADDR_W        32  width of PC / redirect address
//  FLUSH_CYCLES  1   cycles flush is held asserted per exception (>=1)
//  CNT_W         32  width of performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk            in   1       single clock, all state on posedge
//  rst            in   1       synchronous, active-high reset
//  stallreq_if    in   1       IF not ready (icache/bus wait)
//  stallreq_id    in   1       ID hazard (load-use)
//  stallreq_ex    in   1       EX multi-cycle op busy (mul/div)
//  stallreq_mem   in   1       MEM not ready (dcache/bus wait)
//  excp_valid     in   1       MEM-stage exception/eret commit request, 1-cycle pulse
//  excp_pc        in   ADDR_W  target PC for that request
//  stall          out  6       [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb; 1 = hold
//  flush          out  1       clear all pipeline registers to zero/bubble
//  redirect       out  1       pc register loads new_pc this cycle
//  new_pc         out  ADDR_W  redirect target
//  stall_cnt      out  CNT_W   cycles with stall!=0 (0 if feature absent)
//  flush_cnt      out  CNT_W   accepted exceptions (0 if feature absent)
// BEHAVIOUR
//  Reset: state=RUN, stall=0, flush=0, redirect=0, new_pc=0, counters=0.
//  States: RUN, FLUSH. Flush counter fcnt (clog2(FLUSH_CYCLES+1) bits).
//  RUN, stall (combinational, same cycle as request), highest stage wins:
//   stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111;
//   else stallreq_if -> 6'b000011; else 6'b000000. Stages past the highest stalled one proceed; the
//   register directly after it inserts a bubble (pipeline-register rule, not this block).
//  RUN, excp_valid=1: accepted regardless of stall requests; that cycle stall=0 (exception outranks stalls);
//   next cycle: state=FLUSH, flush=1, redirect=1, new_pc=excp_pc (registered), fcnt=FLUSH_CYCLES-1.
//  FLUSH: stall=0, stall requests ignored, excp_valid ignored (source already killed).
//   redirect high only on first FLUSH cycle; flush high every FLUSH cycle; new_pc held stable.
//   fcnt==0 -> RUN next cycle (flush,redirect drop to 0); else fcnt--.
//  Latency: stall 0 cycles; flush/redirect 1 cycle after excp_valid; first refetch the cycle after redirect.
//  excp_valid on the last FLUSH cycle: ignored. Back-to-back exceptions need one RUN cycle between.
//  rst mid-FLUSH: immediate return to RUN, all outputs to reset values next edge.
//  stall is a pure function of state+inputs; flush/redirect/new_pc are flops.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: stall_cnt += 1 each cycle stall!=0; flush_cnt += 1 per accepted excp_valid;
//   both wrap modulo 2^CNT_W, cleared by rst only.
//  Not defined: no counter flops; stall_cnt/flush_cnt tied to 0; ports still present.
// STRUCTURE
//  Shared package pipe_pkg: stage index constants (STG_PC..STG_WB), STALL_W=6, stall-vector constants
//   STALL_NONE/IF/ID/EX/MEM, state enum pipe_ctrl_state_t {RUN, FLUSH}.
//  One sub-module: pipe_stall_enc (combinational priority encoder stallreq_* -> stall vector).
//  FSM, flush counter, redirect regs and optional counters live in pipe_ctrl.
// TESTING
//  1 rst 3 cycles, no requests -> stall=0, flush=0, redirect=0, new_pc=0, counters=0.
//  2 stallreq_id=1 and stallreq_if=1 same cycle -> stall=6'b000111 that cycle; stallreq_mem added -> 6'b011111.
//  3 excp_valid=1, excp_pc=0xBFC00380, stallreq_ex=1 -> stall=0 that cycle; next cycle flush=1, redirect=1,
//    new_pc=0xBFC00380; following cycle flush=0 (FLUSH_CYCLES=1), state RUN.
//  4 FLUSH_CYCLES=3, excp_valid pulse -> flush high 3 cycles, redirect only first; stallreq_mem during
//    FLUSH -> stall=0; second excp_valid during FLUSH ignored (flush_cnt stays 1).
//  5 rst asserted in 2nd FLUSH cycle (FLUSH_CYCLES=3) -> next edge flush=0, redirect=0, new_pc=0, RUN.
//  6 PIPE_PERF_CNT_EN, CNT_W=4: 17 stalled cycles -> stall_cnt=1 (wrap); macro off -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// stage indices, stall-vector constants and the controller state type.
package pipe_pkg;

  // Stage index of each hold bit in the stall vector
  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int STG_WB    = 5;

  localparam int STALL_W = 6;

  // A stall request from stage N holds every register up to and including N
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_enc.sv
// Priority encoder turning per-stage stall requests into a prefix hold
// vector; the deepest requesting stage decides how much of the pipe holds.
module pipe_stall_enc
  import pipe_pkg::*;
(
  input  logic               i_stallreq_if,
  input  logic               i_stallreq_id,
  input  logic               i_stallreq_ex,
  input  logic               i_stallreq_mem,
  output logic [STALL_W-1:0] o_stall
);

  // Deepest stage wins: holding it implies holding everything upstream
  always_comb begin
    o_stall = STALL_NONE;
    if (i_stallreq_mem) begin
      o_stall = STALL_MEM;
    end else if (i_stallreq_ex) begin
      o_stall = STALL_EX;
    end else if (i_stallreq_id) begin
      o_stall = STALL_ID;
    end else if (i_stallreq_if) begin
      o_stall = STALL_IF;
    end else begin
      o_stall = STALL_NONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Stall is combinational from state and requests; flush, redirect and
// new_pc are registered. An accepted exception is followed by
// FLUSH_CYCLES cycles of flush, with redirect on the first of them.
// Optional feature: define PIPE_PERF_CNT_EN to build the stall/flush
// performance counters; otherwise the counter ports are tied to zero.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stallreq_if,
  input  logic               i_stallreq_id,
  input  logic               i_stallreq_ex,
  input  logic               i_stallreq_mem,
  input  logic               i_excp_valid,
  input  logic [ADDR_W-1:0]  i_excp_pc,
  output logic [STALL_W-1:0] o_stall,
  output logic               o_flush,
  output logic               o_redirect,
  output logic [ADDR_W-1:0]  o_new_pc,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

  pipe_ctrl_state_t    r_state;
  pipe_ctrl_state_t    w_state_nxt;
  logic [FCNT_W-1:0]   r_fcnt;
  logic [FCNT_W-1:0]   w_fcnt_nxt;
  logic                r_flush;
  logic                w_flush_nxt;
  logic                r_redirect;
  logic                w_redirect_nxt;
  logic [ADDR_W-1:0]   r_new_pc;
  logic [ADDR_W-1:0]   w_new_pc_nxt;
  logic [STALL_W-1:0]  w_enc_stall;
  logic [STALL_W-1:0]  w_stall;

  pipe_stall_enc u_stall_enc (
    .i_stallreq_if  (i_stallreq_if),
    .i_stallreq_id  (i_stallreq_id),
    .i_stallreq_ex  (i_stallreq_ex),
    .i_stallreq_mem (i_stallreq_mem),
    .o_stall        (w_enc_stall)
  );

  // Next-state, flush sequencing and the combinational stall vector
  always_comb begin
    w_state_nxt    = r_state;
    w_fcnt_nxt     = r_fcnt;
    w_flush_nxt    = 1'b0;
    w_redirect_nxt = 1'b0;
    w_new_pc_nxt   = r_new_pc;
    w_stall        = STALL_NONE;
    case (r_state)
      RUN: begin
        if (i_excp_valid) begin
          // Exception outranks stalls so the flush starts on time
          w_stall        = STALL_NONE;
          w_state_nxt    = FLUSH;
          w_fcnt_nxt     = FCNT_INIT;
          w_flush_nxt    = 1'b1;
          w_redirect_nxt = 1'b1;
          w_new_pc_nxt   = i_excp_pc;
        end else begin
          w_stall     = w_enc_stall;
          w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        // Requests and further exceptions are ignored while flushing
        if (r_fcnt == {FCNT_W{1'b0}}) begin
          w_state_nxt = RUN;
        end else begin
          w_fcnt_nxt  = r_fcnt - FCNT_W'(1);
          w_flush_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, flush counter and registered flush/redirect outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RUN;
      r_fcnt     <= {FCNT_W{1'b0}};
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_new_pc   <= {ADDR_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_flush    <= w_flush_nxt;
      r_redirect <= w_redirect_nxt;
      r_new_pc   <= w_new_pc_nxt;
    end
  end

  assign o_stall    = w_stall;
  assign o_flush    = r_flush;
  assign o_redirect = r_redirect;
  assign o_new_pc   = r_new_pc;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Free-running wrap-around counters, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall != STALL_NONE) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((r_state == RUN) && i_excp_valid) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = {CNT_W{1'b0}};
  assign o_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (FLUSH_CYCLES 1 and 3,
// CNT_W 4) share one stimulus stream and are compared against a
// behavioural model counting remaining flush cycles.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sr_if = 1'b0, sr_id = 1'b0, sr_ex = 1'b0, sr_mem = 1'b0;
  logic        excp = 1'b0;
  logic [31:0] excp_pc = 32'h0;

  logic [5:0]  stall_o [2];
  logic        flush_o [2];
  logic        redir_o [2];
  logic [31:0] npc_o   [2];
  logic [3:0]  scnt_o  [2];
  logic [3:0]  fcnt_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // model state per instance
  int          fc    [2] = '{1, 3};
  int          rem   [2];
  bit          redir [2];
  logic [31:0] npc   [2];
  int          scnt  [2];
  int          fcnt  [2];

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_stallreq_if(sr_if), .i_stallreq_id(sr_id),
    .i_stallreq_ex(sr_ex), .i_stallreq_mem(sr_mem), .i_excp_valid(excp),
    .i_excp_pc(excp_pc), .o_stall(stall_o[0]), .o_flush(flush_o[0]),
    .o_redirect(redir_o[0]), .o_new_pc(npc_o[0]), .o_stall_cnt(scnt_o[0]),
    .o_flush_cnt(fcnt_o[0]));

  pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_stallreq_if(sr_if), .i_stallreq_id(sr_id),
    .i_stallreq_ex(sr_ex), .i_stallreq_mem(sr_mem), .i_excp_valid(excp),
    .i_excp_pc(excp_pc), .o_stall(stall_o[1]), .o_flush(flush_o[1]),
    .o_redirect(redir_o[1]), .o_new_pc(npc_o[1]), .o_stall_cnt(scnt_o[1]),
    .o_flush_cnt(fcnt_o[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of leading pipeline registers that must hold
  function automatic logic [5:0] exp_stall(input int k);
    int depth;
    if (rem[k] != 0 || excp) return 6'd0;
    depth = sr_mem ? 5 : sr_ex ? 4 : sr_id ? 3 : sr_if ? 2 : 0;
    return 6'((64'd1 << depth) - 64'd1);
  endfunction

  function automatic logic [3:0] cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 4'(v % 16);
`else
    return 4'(v * 0);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; redir[k] = 1'b0; npc[k] = 32'h0; scnt[k] = 0; fcnt[k] = 0;
    end
  endtask

  // One clock: check comb stall, clock, update model, check registers
  task automatic step();
    bit stalled [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall[%0d]", k), 64'(stall_o[k]), 64'(exp_stall(k)));
      stalled[k] = (exp_stall(k) != 6'd0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0; redir[k] = 1'b0; npc[k] = 32'h0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (stalled[k]) scnt[k]++;
        if (rem[k] == 0) begin
          redir[k] = 1'b0;
          if (excp) begin
            rem[k] = fc[k]; redir[k] = 1'b1; npc[k] = excp_pc; fcnt[k]++;
          end
        end else begin
          rem[k]--; redir[k] = 1'b0;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush[%0d]", k), 64'(flush_o[k]), 64'(rem[k] != 0));
      chk($sformatf("redirect[%0d]", k), 64'(redir_o[k]), 64'(redir[k]));
      chk($sformatf("new_pc[%0d]", k), 64'(npc_o[k]), 64'(npc[k]));
      chk($sformatf("stall_cnt[%0d]", k), 64'(scnt_o[k]), 64'(cnt_exp(scnt[k])));
      chk($sformatf("flush_cnt[%0d]", k), 64'(fcnt_o[k]), 64'(cnt_exp(fcnt[k])));
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic e, input logic [31:0] pc);
    rst = r; sr_if = req[0]; sr_id = req[1]; sr_ex = req[2]; sr_mem = req[3];
    excp = e; excp_pc = pc;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // 1: reset for 3 cycles with no requests
    drive(1'b1, 4'b0000, 1'b0, 32'h0);
    repeat (3) step();
    chk("rst_flush", 64'(flush_o[1]), 64'd0);
    chk("rst_new_pc", 64'(npc_o[1]), 64'd0);
    // 2: IF+ID stall, then MEM on top
    drive(1'b0, 4'b0011, 1'b0, 32'h0);
    #1 chk("stall_id_if", 64'(stall_o[0]), 64'h07);
    step();
    drive(1'b0, 4'b1011, 1'b0, 32'h0);
    #1 chk("stall_mem", 64'(stall_o[0]), 64'h1F);
    step();
    // 3: exception beats EX stall
    drive(1'b0, 4'b0100, 1'b1, 32'hBFC00380);
    #1 chk("excp_stall0", 64'(stall_o[0]), 64'h0);
    step();
    chk("excp_redirect", 64'(redir_o[0]), 64'd1);
    chk("excp_new_pc", 64'(npc_o[0]), 64'hBFC00380);
    // 4: stall requests and a second exception during FLUSH
    drive(1'b0, 4'b1000, 1'b1, 32'h12345678);
    step();
    chk("fc1_back_to_run", 64'(flush_o[0]), 64'd0);
    chk("fc3_still_flush", 64'(flush_o[1]), 64'd1);
    chk("fc3_new_pc_held", 64'(npc_o[1]), 64'hBFC00380);
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    repeat (3) step();
    chk("fc3_flush_done", 64'(flush_o[1]), 64'd0);
    // 5: reset in the 2nd FLUSH cycle of the 3-cycle instance
    drive(1'b0, 4'b0000, 1'b1, 32'hCAFE0000);
    step();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    step();
    drive(1'b1, 4'b0000, 1'b0, 32'h0);
    step();
    chk("midflush_rst_flush", 64'(flush_o[1]), 64'd0);
    chk("midflush_rst_pc", 64'(npc_o[1]), 64'd0);
    // 6: 17 stalled cycles wrap a 4-bit counter to 1
    drive(1'b0, 4'b0001, 1'b0, 32'h0);
    repeat (17) step();
    chk("stall_cnt_wrap", 64'(scnt_o[0]), 64'(cnt_exp(17)));
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(63) == 0), 4'($urandom_range(15)),
            ($urandom_range(7) == 0), $urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
